// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter family.
// Direction/mode encodings and load clamping live here.
package counter_pkg;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  typedef enum logic {MODE_SAT = 1'b0, MODE_WRAP = 1'b1} mode_e;

  // Load values above the limit are pinned to the limit.
  function automatic logic [63:0] clamp_load(
    input logic [63:0] d,
    input logic [63:0] max
  );
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count for a bounded up/down counter.
// Flags a boundary event when a step hits 0 or MAX.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned     W   = 8,
  parameter longint unsigned MAX = (64'd1 << W) - 64'd1
) (
  input  logic [W-1:0] y_i,
  input  dir_e         dir_i,
  input  mode_e        wrap_i,
  input  logic         en_i,
  output logic [W-1:0] y_o,
  output logic         evt_o
);

  localparam int unsigned W1   = W + 1;
  localparam logic [W:0]  MaxE = W1'(MAX);
  localparam logic [W:0]  One  = W1'(1);

  // One spare bit keeps MAX = 2**W-1 from wrapping silently.
  logic [W:0] y_ext;
  assign y_ext = {1'b0, y_i};

  always_comb begin
    y_o   = y_i;
    evt_o = 1'b0;
    if (en_i) begin
      unique case (dir_i)
        DIR_UP: begin
          if (y_ext < MaxE) begin
            y_o = W'(y_ext + One);
          end else begin
            evt_o = 1'b1;
            y_o   = (wrap_i == MODE_WRAP) ? '0 : W'(MaxE);
          end
        end
        DIR_DOWN: begin
          if (y_ext != '0) begin
            y_o = W'(y_ext - One);
          end else begin
            evt_o = 1'b1;
            y_o   = (wrap_i == MODE_WRAP) ? W'(MaxE) : '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Bounded up/down counter with load, clear, wrap/saturate,
// boundary flags, terminal-count pulse and sticky overflow.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned     W   = 8,
  parameter longint unsigned MAX = (64'd1 << W) - 64'd1
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic         EN,
  input  logic         DIR,
  input  logic         WRAP,
  input  logic         LOAD,
  input  logic [W-1:0] D,
  input  logic         CLR,
  output logic [W-1:0] Y,
  output logic         AT_MIN,
  output logic         AT_MAX,
  output logic         TC,
  output logic         OVF
);

  if (W < 1 || W > 63 || MAX < 1 || MAX > ((64'd1 << W) - 64'd1))
  begin : g_bad_param
    $error("updown_counter_mod: MAX out of range 1..2**W-1");
  end

  localparam logic [W-1:0] MaxY = W'(MAX);

  logic [W-1:0] y_q, y_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] y_step;
  logic         evt;
  logic [W-1:0] y_load;

  counter_next #(
    .W   (W),
    .MAX (MAX)
  ) u_next (
    .y_i    (y_q),
    .dir_i  (dir_e'(DIR)),
    .wrap_i (mode_e'(WRAP)),
    .en_i   (EN),
    .y_o    (y_step),
    .evt_o  (evt)
  );

  assign y_load = W'(clamp_load(64'(D), MAX));

  // CLR beats LOAD beats EN; TC only lives for the cycle after an event.
  always_comb begin
    y_d   = y_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (CLR) begin
      y_d   = '0;
      ovf_d = 1'b0;
    end else if (LOAD) begin
      y_d = y_load;
    end else if (EN) begin
      y_d   = y_step;
      tc_d  = evt;
      ovf_d = ovf_q | evt;
    end
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      y_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign Y      = y_q;
  assign TC     = tc_q;
  assign OVF    = ovf_q;
  assign AT_MIN = (y_q == '0);
  assign AT_MAX = (y_q == MaxY);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod at W=4, MAX=9.
// Directed scenarios plus random traffic against a behavioural model.
module tb_updown_counter_mod;

  localparam int MAXV = 9;

  logic       CLK = 1'b0;
  logic       N_RESET;
  logic       EN, DIR, WRAP, LOAD, CLR;
  logic [3:0] D;
  logic [3:0] Y;
  logic       AT_MIN, AT_MAX, TC, OVF;

  int total = 0;
  int bad   = 0;
  int my, mtc, movf;

  updown_counter_mod #(.W(4), .MAX(MAXV)) dut (
    .CLK     (CLK),
    .N_RESET (N_RESET),
    .EN      (EN),
    .DIR     (DIR),
    .WRAP    (WRAP),
    .LOAD    (LOAD),
    .D       (D),
    .CLR     (CLR),
    .Y       (Y),
    .AT_MIN  (AT_MIN),
    .AT_MAX  (AT_MAX),
    .TC      (TC),
    .OVF     (OVF)
  );

  always #5 CLK = ~CLK;

  // Reference: the counting rules written as plain integer arithmetic.
  task automatic model_step();
    if (!N_RESET) begin
      my = 0; mtc = 0; movf = 0;
    end else if (CLR) begin
      my = 0; mtc = 0; movf = 0;
    end else if (LOAD) begin
      my  = (int'(D) > MAXV) ? MAXV : int'(D);
      mtc = 0;
    end else if (EN) begin
      if (!DIR) begin
        if (my < MAXV) begin my = my + 1; mtc = 0; end
        else begin my = WRAP ? 0 : MAXV; mtc = 1; movf = 1; end
      end else begin
        if (my > 0) begin my = my - 1; mtc = 0; end
        else begin my = WRAP ? MAXV : 0; mtc = 1; movf = 1; end
      end
    end else begin
      mtc = 0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle();
    EN = 0; DIR = 0; WRAP = 0; LOAD = 0; CLR = 0; D = '0;
  endtask

  task automatic test_reset();
    idle();
    N_RESET = 1'b0;
    my = 0; mtc = 0; movf = 0;
    #3;
    total++;
    if (Y !== 4'd0 || TC !== 1'b0 || OVF !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals Y=%0d TC=%b OVF=%b exp 0 0 0", Y, TC, OVF);
    end
    total++;
    if (AT_MIN !== 1'b1 || AT_MAX !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags AT_MIN=%b AT_MAX=%b exp 1 0", AT_MIN, AT_MAX);
    end
    @(negedge CLK);
    N_RESET = 1'b1;
  endtask

  task automatic test_wrap_up();
    int tcs;
    tcs = 0;
    EN = 1; DIR = 0; WRAP = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (TC === 1'b1) tcs++;
      total++;
      if (Y !== 4'(my) || TC !== 1'(mtc)) begin
        bad++;
        $display("FAIL wrap_up cyc=%0d Y=%0d TC=%b exp %0d %0d", i, Y, TC, my, mtc);
      end
    end
    total++;
    if (Y !== 4'd2 || tcs != 1 || OVF !== 1'b1) begin
      bad++;
      $display("FAIL wrap_up_end Y=%0d tcs=%0d OVF=%b exp 2 1 1", Y, tcs, OVF);
    end
    idle();
  endtask

  task automatic test_saturate_up();
    LOAD = 1; D = 4'd8;
    tick();
    idle();
    EN = 1; DIR = 0; WRAP = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (Y !== 4'(my) || TC !== 1'(mtc) || AT_MAX !== 1'b1) begin
        bad++;
        $display("FAIL sat_up cyc=%0d Y=%0d TC=%b AT_MAX=%b exp %0d %0d 1",
                 i, Y, TC, AT_MAX, my, mtc);
      end
    end
    idle();
  endtask

  task automatic test_load_clamp_down();
    LOAD = 1; D = 4'hF;
    tick();
    total++;
    if (Y !== 4'd9 || TC !== 1'b0) begin
      bad++;
      $display("FAIL load_clamp Y=%0d TC=%b exp 9 0", Y, TC);
    end
    idle();
    EN = 1; DIR = 1; WRAP = 1;
    for (int i = 0; i < 11; i++) begin
      tick();
      total++;
      if (Y !== 4'(my) || TC !== 1'(mtc) || AT_MIN !== (my == 0)) begin
        bad++;
        $display("FAIL down_wrap cyc=%0d Y=%0d TC=%b AT_MIN=%b exp %0d %0d",
                 i, Y, TC, AT_MIN, my, mtc);
      end
    end
    idle();
  endtask

  task automatic test_clr_priority();
    LOAD = 1; D = 4'd5;
    tick();
    total++;
    if (Y !== 4'd5 || OVF !== 1'b1) begin
      bad++;
      $display("FAIL clr_pre Y=%0d OVF=%b exp 5 1", Y, OVF);
    end
    CLR = 1; LOAD = 1; EN = 1; D = 4'd7;
    tick();
    total++;
    if (Y !== 4'd0 || OVF !== 1'b0 || TC !== 1'b0) begin
      bad++;
      $display("FAIL clr_prio Y=%0d OVF=%b TC=%b exp 0 0 0", Y, OVF, TC);
    end
    idle();
  endtask

  task automatic test_async_reset();
    LOAD = 1; D = 4'd9;
    tick();
    idle();
    EN = 1; DIR = 0; WRAP = 0;
    tick();
    total++;
    if (Y !== 4'd9 || TC !== 1'b1 || OVF !== 1'b1) begin
      bad++;
      $display("FAIL arst_pre Y=%0d TC=%b OVF=%b exp 9 1 1", Y, TC, OVF);
    end
    #2;
    N_RESET = 1'b0;
    my = 0; mtc = 0; movf = 0;
    #1;
    total++;
    if (Y !== 4'd0 || TC !== 1'b0 || OVF !== 1'b0 || AT_MIN !== 1'b1) begin
      bad++;
      $display("FAIL arst_mid Y=%0d TC=%b OVF=%b AT_MIN=%b exp 0 0 0 1",
               Y, TC, OVF, AT_MIN);
    end
    tick();
    total++;
    if (Y !== 4'd0 || TC !== 1'b0) begin
      bad++;
      $display("FAIL arst_hold Y=%0d TC=%b exp 0 0", Y, TC);
    end
    @(negedge CLK);
    N_RESET = 1'b1;
    idle();
  endtask

  task automatic test_dir_toggle();
    CLR = 1;
    tick();
    idle();
    EN = 1; WRAP = 0; DIR = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (Y !== 4'(my) || TC !== 1'(mtc) || OVF !== 1'(movf)) begin
        bad++;
        $display("FAIL dir_toggle cyc=%0d Y=%0d TC=%b OVF=%b exp %0d %0d %0d",
                 i, Y, TC, OVF, my, mtc, movf);
      end
      DIR = ~DIR;
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      CLR  = ($urandom_range(0, 19) == 0);
      LOAD = ($urandom_range(0, 9) == 0);
      EN   = ($urandom_range(0, 3) != 0);
      DIR  = 1'($urandom);
      WRAP = 1'($urandom);
      D    = 4'($urandom);
      tick();
      total++;
      if (Y !== 4'(my) || TC !== 1'(mtc) || OVF !== 1'(movf) ||
          AT_MIN !== (my == 0) || AT_MAX !== (my == MAXV)) begin
        bad++;
        $display("FAIL random cyc=%0d Y=%0d TC=%b OVF=%b min=%b max=%b exp %0d %0d %0d",
                 i, Y, TC, OVF, AT_MIN, AT_MAX, my, mtc, movf);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_saturate_up();
    test_load_clamp_down();
    test_clr_priority();
    test_async_reset();
    test_dir_toggle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
